// File: rtl/shift_initiator.sv
// shift_initiator: queues shift requests and sequences them into the shifter one op at a time.
// Latency: pop -> ISSUE next cycle; result sampled LATENCY cycles after ISSUE; response held until accepted.
// Backpressure: req_ready = FIFO not full; no new issue while a response is unaccepted. Optional SHIFT_CHECK_EN adds a result model.
module shift_initiator #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = 5,
  parameter int OPS         = 2,
  parameter int LATENCY     = 1,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_data,
  input  logic [SHIFT_WIDTH-1:0] req_shift,
  input  logic [OPS-1:0]         req_op,
  output logic [WIDTH-1:0]       sh_data,
  output logic [SHIFT_WIDTH-1:0] sh_shift,
  output logic [OPS-1:0]         sh_op,
  output logic                   sh_start,
  input  logic [WIDTH-1:0]       sh_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_mismatch,
  output logic [7:0]             err_count,
  output logic                   busy
);

  // Shifter op encodings.
  localparam logic [OPS-1:0] LEFT_SHIFTL  = OPS'(0);
  localparam logic [OPS-1:0] LEFT_SHIFTA  = OPS'(1);
  localparam logic [OPS-1:0] RIGHT_SHIFTL = OPS'(2);
  localparam logic [OPS-1:0] RIGHT_SHIFTA = OPS'(3);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          EW      = WIDTH + SHIFT_WIDTH + OPS;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t         state, state_nxt;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, push, pop, sample, rsp_clr;
  logic [3:0]     wait_cnt;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign busy      = (state != IDLE) || !empty;

  // FIFO pointers; a pop never frees space for a push in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {req_data, req_shift, req_op};
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nxt = state;
    sh_start  = 1'b0;
    pop       = 1'b0;
    sample    = 1'b0;
    rsp_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        sh_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt + 4'd1 == 4'(LATENCY)) begin
          sample    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers: loaded on pop, held until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data  <= '0;
      sh_shift <= '0;
      sh_op    <= '0;
    end else if (pop) begin
      {sh_data, sh_shift, sh_op} <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Wait counter: cleared on pop, counts WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst)                wait_cnt <= '0;
    else if (pop)           wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
  end

  // Response capture and hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else if (sample) begin
      rsp_valid  <= 1'b1;
      rsp_result <= sh_result;
    end else if (rsp_clr) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef SHIFT_CHECK_EN
  logic [WIDTH-1:0] expected;

  // Reference result for the issued operands; unknown op codes pass data through.
  always_comb begin
    expected = sh_data;
    case (sh_op)
      LEFT_SHIFTA, LEFT_SHIFTL: expected = sh_data << sh_shift;
      RIGHT_SHIFTL:             expected = sh_data >> sh_shift;
      RIGHT_SHIFTA:             expected = WIDTH'($signed(sh_data) >>> sh_shift);
      default:                  expected = sh_data;
    endcase
  end

  // Mismatch flag travels with rsp_result; error count saturates at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_mismatch <= 1'b0;
      err_count    <= '0;
    end else if (sample) begin
      rsp_mismatch <= (sh_result != expected);
      if ((sh_result != expected) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end
`else
  assign rsp_mismatch = 1'b0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_shift_initiator.sv
module tb_shift_initiator;

  localparam int DEPTH = 4;
  localparam int L1    = 1;
  localparam int L2    = 3;
  localparam logic [1:0] LSL = 2'd0, LSA = 2'd1, RSL = 2'd2, RSA = 2'd3;
`ifdef SHIFT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 1: LATENCY 1, combinational shifter model
  logic        req_valid, req_ready, sh_start, rsp_valid, rsp_ready, rsp_mismatch, busy;
  logic [31:0] req_data, sh_data, sh_result, rsp_result;
  logic [4:0]  req_shift, sh_shift;
  logic [1:0]  req_op, sh_op;
  logic [7:0]  err_count;

  // DUT 2: LATENCY 3, registered shifter model of depth 3 or 4
  logic        req2_valid, req2_ready, sh2_start, rsp2_valid, rsp2_ready, rsp2_mismatch, busy2;
  logic [31:0] req2_data, sh2_data, sh2_result, rsp2_result;
  logic [4:0]  req2_shift, sh2_shift;
  logic [1:0]  req2_op, sh2_op;
  logic [7:0]  err2_count;

  shift_initiator #(.WIDTH(32), .SHIFT_WIDTH(5), .OPS(2), .LATENCY(L1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_shift(req_shift), .req_op(req_op), .sh_data(sh_data), .sh_shift(sh_shift), .sh_op(sh_op),
    .sh_start(sh_start), .sh_result(sh_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy));

  shift_initiator #(.WIDTH(32), .SHIFT_WIDTH(5), .OPS(2), .LATENCY(L2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req2_valid), .req_ready(req2_ready), .req_data(req2_data),
    .req_shift(req2_shift), .req_op(req2_op), .sh_data(sh2_data), .sh_shift(sh2_shift), .sh_op(sh2_op),
    .sh_start(sh2_start), .sh_result(sh2_result), .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready),
    .rsp_result(rsp2_result), .rsp_mismatch(rsp2_mismatch), .err_count(err2_count), .busy(busy2));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit zero_mode = 1'b0;
  bit pipe4 = 1'b0;

  // Bit-serial shift model: one position per step, fill bit by op kind.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) begin
      case (op)
        LSL, LSA: r = {r[30:0], 1'b0};
        RSL:      r = {1'b0, r[31:1]};
        default:  r = {r[31], r[31:1]};
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifter models driven by the DUT outputs
  always_comb sh_result = zero_mode ? 32'h0 : ref_shift(sh_data, sh_shift, sh_op);

  logic [31:0] pipe [4];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= ref_shift(sh2_data, sh2_shift, sh2_op);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sh2_result = pipe4 ? pipe[3] : pipe[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for DUT 1: accepted requests in order, compared at response handshake
  typedef struct {logic [31:0] d; logic [4:0] s; logic [1:0] op;} req_t;
  req_t        sbq[$];
  logic [31:0] rsp_log[$];
  int          issue_log[$];
  int          err_model = 0;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      err_model = 0;
    end else begin
      if (req_valid && req_ready) sbq.push_back('{req_data, req_shift, req_op});
      if (sh_start) issue_log.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          timeout("rsp_without_request");
        end else begin
          req_t        r;
          logic [31:0] good, exp_res;
          logic        mm;
          r       = sbq.pop_front();
          good    = ref_shift(r.d, r.s, r.op);
          exp_res = zero_mode ? 32'h0 : good;
          mm      = CHK && (exp_res != good);
          check("sb_rsp_result", rsp_result, exp_res);
          check("sb_rsp_mismatch", {31'b0, rsp_mismatch}, {31'b0, mm});
          if (mm && err_model < 255) err_model++;
          rsp_log.push_back(rsp_result);
        end
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_data  = d;
    req_shift = s;
    req_op    = op;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!done) timeout("push");
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (!busy && !rsp_valid) done = 1'b1;
      else tick();
    end
    if (!done) timeout("wait_idle");
  endtask

  // One operation on DUT 2: returns captured result, mismatch and issue-to-valid cycles
  task automatic op2(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                     output logic [31:0] res, output logic mm, output int lat);
    int  t_iss;
    bit  got;
    t_iss = -1;
    got   = 1'b0;
    res   = '0;
    mm    = 1'b0;
    lat   = -1;
    req2_valid = 1'b1; req2_data = d; req2_shift = s; req2_op = op;
    tick();
    req2_valid = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (sh2_start && t_iss < 0) t_iss = k;
      if (rsp2_valid) begin
        got = 1'b1;
        res = rsp2_result;
        mm  = rsp2_mismatch;
        lat = k - t_iss;
      end
      tick();
    end
    if (!got) timeout("op2_response");
  endtask

  typedef struct {logic [31:0] d; logic [4:0] s; logic [1:0] op; logic [31:0] exp;} vec_t;
  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, ib, acc, t_issue, t_rsp, nstart, viol, lat;
    logic [31:0] held, r2, ra, rb, rc, rd;
    logic        m2;
    bit          seen;

    tbl[0] = '{32'h0000_0001, 5'd31, LSL, 32'h8000_0000};
    tbl[1] = '{32'h8000_0000, 5'd4,  RSL, 32'h0800_0000};
    tbl[2] = '{32'h0000_000F, 5'd4,  LSA, 32'h0000_00F0};
    tbl[3] = '{32'h1234_5678, 5'd0,  RSL, 32'h1234_5678};
    tbl[4] = '{32'h7FFF_FFFF, 5'd31, RSA, 32'h0000_0000};
    tbl[5] = '{32'hFFFF_FFFF, 5'd31, RSA, 32'hFFFF_FFFF};

    rst = 1'b1;
    req_valid = 1'b0; req_data = '0; req_shift = '0; req_op = '0; rsp_ready = 1'b1;
    req2_valid = 1'b0; req2_data = '0; req2_shift = '0; req2_op = '0; rsp2_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_sh_start", {31'b0, sh_start}, 32'd0);
    check("rst_sh_data", sh_data, 32'd0);
    check("rst_sh_shift", {27'b0, sh_shift}, 32'd0);
    check("rst_sh_op", {30'b0, sh_op}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_mismatch", {31'b0, rsp_mismatch}, 32'd0);
    check("rst_err_count", {24'b0, err_count}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Single RIGHT_SHIFTA op: one start pulse, response LATENCY+1 cycles after ISSUE
    t_issue = -1; t_rsp = -1; nstart = 0; held = '0;
    push(32'h8000_0000, 5'd4, RSA);
    for (int k = 0; k < 12; k++) begin
      if (sh_start) begin
        nstart++;
        if (t_issue < 0) t_issue = k;
      end
      if (rsp_valid && t_rsp < 0) begin
        t_rsp = k;
        held  = rsp_result;
        check("single_mismatch", {31'b0, rsp_mismatch}, 32'd0);
      end
      tick();
    end
    check("single_start_count", nstart, 1);
    check("single_latency", t_rsp - t_issue, L1 + 1);
    check("single_result", held, 32'hF800_0000);

    // Table: back-to-back pushes, in-order responses, exact issue spacing
    base = rsp_log.size();
    ib   = issue_log.size();
    rsp_ready = 1'b1;
    foreach (tbl[i]) push(tbl[i].d, tbl[i].s, tbl[i].op);
    begin
      bit done;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
        if (rsp_log.size() >= base + 6) done = 1'b1;
        else tick();
      end
      if (!done) timeout("table_responses");
    end
    for (int i = 0; i < 6; i++)
      if (base + i < rsp_log.size()) check($sformatf("table_rsp_%0d", i), rsp_log[base+i], tbl[i].exp);
    check("table_issue_count", issue_log.size() - ib, 6);
    for (int i = 1; i < 6; i++)
      if (ib + i < issue_log.size())
        check($sformatf("table_spacing_%0d", i), issue_log[ib+i] - issue_log[ib+i-1], L1 + 3);
    wait_idle();

    // Full FIFO with response backpressure
    base = rsp_log.size();
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_data = 32'hA5A5_0001; req_shift = 5'd0; req_op = LSL;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready) acc++;
      tick();
      req_data = 32'hA5A5_0001 + acc; req_shift = 5'(acc); req_op = 2'(acc);
    end
    req_valid = 1'b0;
    check("full_accepted", acc, DEPTH + 1);
    check("full_req_ready", {31'b0, req_ready}, 32'd0);
    check("full_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    held = rsp_result;
    check("full_held_value", held, ref_shift(32'hA5A5_0001, 5'd0, LSL));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("full_hold_stable", rsp_result, held);
    end
    rsp_ready = 1'b1;
    wait_idle();
    repeat (4) tick();
    check("full_rsp_count", rsp_log.size() - base, DEPTH + 1);
    check("full_sb_empty", sbq.size(), 0);

    // Reset during WAIT with two requests queued
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_data = 32'h0F0F_0000 + k; req_shift = 5'd1; req_op = RSL;
      tick();
      if (k == 1) check("rstw_issue_seen", {31'b0, sh_start}, 32'd1);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstw_busy", {31'b0, busy}, 32'd0);
    check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    check("rstw_sh_start", {31'b0, sh_start}, 32'd0);
    check("rstw_sh_data", sh_data, 32'd0);
    check("rstw_sh_shift_op", {25'b0, sh_shift, sh_op}, 32'd0);
    check("rstw_rsp_result", rsp_result, 32'd0);
    check("rstw_err_count", {24'b0, err_count}, 32'd0);
    seen = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid || sh_start) seen = 1'b1;
      tick();
    end
    check("rstw_no_activity", {31'b0, seen}, 32'd0);

    // Latency sweep on DUT 2: 3-deep shifter is captured correctly, 4-deep yields the stale value
    op2(32'h0000_00FF, 5'd8, LSL, r2, m2, lat);
    check("lat3_a_result", r2, 32'h0000_FF00);
    check("lat3_a_mismatch", {31'b0, m2}, 32'd0);
    check("lat3_a_latency", lat, L2 + 1);
    op2(32'hF000_0000, 5'd4, RSA, r2, m2, lat);
    check("lat3_b_result", r2, 32'hFF00_0000);
    check("lat3_b_mismatch", {31'b0, m2}, 32'd0);
    pipe4 = 1'b1;
    repeat (5) tick();
    rb = ref_shift(32'hF000_0000, 5'd4, RSA);
    rc = ref_shift(32'h1234_5678, 5'd4, RSL);
    rd = ref_shift(32'h8000_0001, 5'd1, LSA);
    op2(32'h1234_5678, 5'd4, RSL, r2, m2, lat);
    check("lat4_c_stale", r2, rb);
    check("lat4_c_mismatch", {31'b0, m2}, {31'b0, CHK && (rb != rc)});
    op2(32'h8000_0001, 5'd1, LSA, ra, m2, lat);
    check("lat4_d_stale", ra, rc);
    check("lat4_d_mismatch", {31'b0, m2}, {31'b0, CHK && (rc != rd)});
    pipe4 = 1'b0;

    // Random traffic on DUT 1 against the scoreboard
    ib = issue_log.size();
    for (int k = 0; k < 1500; k++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_data  = $urandom;
      req_shift = 5'($urandom_range(0, 31));
      req_op    = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (2) tick();
    check("rand_sb_empty", sbq.size(), 0);
    viol = 0;
    for (int i = ib + 1; i < issue_log.size(); i++)
      if (issue_log[i] - issue_log[i-1] < L1 + 3) viol++;
    check("rand_min_spacing", viol, 0);

    // Shifter forced to zero for 300 ops: error count saturates in the check build
    zero_mode = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 300; k++)
      push($urandom | 32'h1, 5'd0, 2'($urandom_range(0, 3)));
    wait_idle();
    repeat (2) tick();
    check("zero_err_model", {24'b0, err_count}, err_model);
    check("zero_err_sat", {24'b0, err_count}, CHK ? 32'd255 : 32'd0);
    check("zero_last_mismatch", {31'b0, rsp_mismatch}, {31'b0, CHK});
    zero_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
